// File: rtl/rename_pkg.sv
// Shared rename-stage constants and tag types for the physical free list.
package rename_pkg;

    localparam int unsigned PHYS_REGS = 64;
    localparam int unsigned ARCH_REGS = 32;
    localparam int unsigned ALLOC_W   = 2;
    localparam int unsigned FREE_W    = 2;
    localparam int unsigned CKPTS     = 4;

    localparam int unsigned PW       = $clog2(PHYS_REGS);
    localparam int unsigned CW       = PW + 1;
    localparam int unsigned CAPACITY = PHYS_REGS - ARCH_REGS;
    localparam int unsigned CKPT_W   = (CKPTS > 1) ? $clog2(CKPTS) : 1;
    localparam int unsigned AW       = $clog2(ALLOC_W + 1);
    localparam int unsigned FW       = $clog2(FREE_W + 1);

    typedef logic [PW-1:0]     phys_tag_t;
    typedef logic [CKPT_W-1:0] ckpt_idx_t;
    typedef logic [CW-1:0]     count_t;

endpackage

// File: rtl/prefix_rank.sv
// Per-bit exclusive prefix popcount plus total popcount of a request vector.
module prefix_rank #(
    parameter int unsigned N = 2,
    localparam int unsigned RW = $clog2(N + 1)
) (
    input  logic [N-1:0]         vec,
    output logic [N-1:0][RW-1:0] rank,
    output logic [RW-1:0]        total
);

    logic [RW-1:0] acc;

    always_comb begin
        acc  = '0;
        rank = '0;
        for (int unsigned i = 0; i < N; i++) begin
            rank[i] = acc;
            acc     = acc + RW'(vec[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/phys_free_list.sv
// Multi-port circular free list of physical tags with head checkpoints for
// single-cycle mispredict recovery.
module phys_free_list
    import rename_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic      [ALLOC_W-1:0]      alloc_req,
    output logic                         alloc_ready,
    output phys_tag_t [ALLOC_W-1:0]      alloc_phys,
    input  logic      [FREE_W-1:0]       free_en,
    input  phys_tag_t [FREE_W-1:0]       free_phys,
    input  logic                         ckpt_save,
    input  ckpt_idx_t                    ckpt_idx,
    input  logic                         restore_en,
    input  ckpt_idx_t                    restore_idx,
    output count_t                       free_count,
    output logic                         overflow_err
);

    phys_tag_t queue [PHYS_REGS];
    phys_tag_t ckpt  [CKPTS];
    phys_tag_t head;
    phys_tag_t tail;
    count_t    count;

    logic [ALLOC_W-1:0][AW-1:0] alloc_rank;
    logic [AW-1:0]              nalloc;
    logic [FREE_W-1:0][FW-1:0]  free_rank;
    logic [FW-1:0]              nfree;

    logic [AW-1:0] nalloc_fired;
    logic [FW-1:0] nfree_acc;
    logic          free_ok;
    count_t        count_after;
    count_t        count_next;
    phys_tag_t     head_next;
    phys_tag_t     tail_next;
    phys_tag_t     restore_diff;

    prefix_rank #(.N(ALLOC_W)) u_alloc_rank (
        .vec   (alloc_req),
        .rank  (alloc_rank),
        .total (nalloc)
    );

    prefix_rank #(.N(FREE_W)) u_free_rank (
        .vec   (free_en),
        .rank  (free_rank),
        .total (nfree)
    );

    // All-or-nothing grant; the free group is dropped whole if it would overfill.
    always_comb begin
        alloc_phys   = '0;
        alloc_ready  = (count >= CW'(nalloc)) && !restore_en;
        nalloc_fired = alloc_ready ? nalloc : '0;
        for (int unsigned i = 0; i < ALLOC_W; i++) begin
            alloc_phys[i] = queue[head + PW'(alloc_rank[i])];
        end
        count_after  = count - CW'(nalloc_fired);
        free_ok      = (count_after + CW'(nfree)) <= CW'(CAPACITY);
        nfree_acc    = free_ok ? nfree : '0;
        head_next    = head + PW'(nalloc_fired);
        tail_next    = tail + PW'(nfree_acc);
        count_next   = count_after + CW'(nfree_acc);
        restore_diff = tail_next - ckpt[restore_idx];
    end

    assign free_count = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < PHYS_REGS; i++) begin
                queue[i] <= (i < CAPACITY) ? PW'(ARCH_REGS + i) : '0;
            end
            for (int unsigned k = 0; k < CKPTS; k++) begin
                ckpt[k] <= '0;
            end
            head         <= '0;
            tail         <= PW'(CAPACITY);
            count        <= CW'(CAPACITY);
            overflow_err <= 1'b0;
        end else begin
            for (int unsigned j = 0; j < FREE_W; j++) begin
                if (free_en[j] && free_ok) begin
                    queue[tail + PW'(free_rank[j])] <= free_phys[j];
                end
            end
            if ((nfree != '0) && !free_ok) begin
                overflow_err <= 1'b1;
            end
            tail <= tail_next;
            // Restore wins over allocation and checkpoint save in the same cycle.
            if (restore_en) begin
                head  <= ckpt[restore_idx];
                count <= ((restore_diff == '0) && (count != '0)) ? CW'(CAPACITY)
                                                                  : CW'(restore_diff);
            end else begin
                head  <= head_next;
                count <= count_next;
                if (ckpt_save) begin
                    ckpt[ckpt_idx] <= head_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_phys_free_list.sv
// Directed and scoreboard-driven bench for the multi-port physical free list.
module tb_phys_free_list;
    import rename_pkg::*;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [ALLOC_W-1:0]           alloc_req;
    logic                         alloc_ready;
    logic [ALLOC_W-1:0][PW-1:0]   alloc_phys;
    logic [FREE_W-1:0]            free_en;
    logic [FREE_W-1:0][PW-1:0]    free_phys;
    logic                         ckpt_save;
    logic [CKPT_W-1:0]            ckpt_idx;
    logic                         restore_en;
    logic [CKPT_W-1:0]            restore_idx;
    logic [CW-1:0]                free_count;
    logic                         overflow_err;

    int errors = 0;
    int checks = 0;

    int fl[$];
    int pool[$];

    always #5 clk = ~clk;

    phys_free_list dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_req    (alloc_req),
        .alloc_ready  (alloc_ready),
        .alloc_phys   (alloc_phys),
        .free_en      (free_en),
        .free_phys    (free_phys),
        .ckpt_save    (ckpt_save),
        .ckpt_idx     (ckpt_idx),
        .restore_en   (restore_en),
        .restore_idx  (restore_idx),
        .free_count   (free_count),
        .overflow_err (overflow_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        alloc_req   = '0;
        free_en     = '0;
        free_phys   = '0;
        ckpt_save   = 1'b0;
        ckpt_idx    = '0;
        restore_en  = 1'b0;
        restore_idx = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int nreq;
        int r;
        int idx;
        logic exp_ready;
        logic [ALLOC_W-1:0] rq;
        logic [FREE_W-1:0]  fe;

        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Reset state and first allocation
        alloc_req = 2'b11;
        #1;
        chk("rst_count", 32'(free_count), 32);
        chk("rst_ovf", 32'(overflow_err), 0);
        chk("rst_ready", 32'(alloc_ready), 1);
        chk("alloc0_tag", 32'(alloc_phys[0]), 32);
        chk("alloc1_tag", 32'(alloc_phys[1]), 33);
        tick();
        chk("count_30", 32'(free_count), 30);
        alloc_req = 2'b10;
        #1;
        chk("slot1_rank0", 32'(alloc_phys[1]), 34);
        chk("slot1_ready", 32'(alloc_ready), 1);
        tick();
        chk("count_29", 32'(free_count), 29);

        // Drain down to one, then test all-or-nothing
        alloc_req = 2'b11;
        for (int k = 0; k < 14; k++) tick();
        chk("count_1", 32'(free_count), 1);
        #1;
        chk("short_ready", 32'(alloc_ready), 0);
        tick();
        chk("count_stays_1", 32'(free_count), 1);
        alloc_req = 2'b01;
        #1;
        chk("last_tag", 32'(alloc_phys[0]), 63);
        chk("last_ready", 32'(alloc_ready), 1);
        tick();
        chk("count_0", 32'(free_count), 0);
        #1;
        chk("empty_ready", 32'(alloc_ready), 0);
        alloc_req = 2'b00;
        #1;
        chk("empty_noreq_ready", 32'(alloc_ready), 1);

        // Free two tags into an empty list
        free_en   = 2'b11;
        free_phys[0] = 6'd5;
        free_phys[1] = 6'd7;
        tick();
        idle();
        alloc_req = 2'b11;
        #1;
        chk("freed_tag0", 32'(alloc_phys[0]), 5);
        chk("freed_tag1", 32'(alloc_phys[1]), 7);
        chk("freed_count", 32'(free_count), 2);
        chk("freed_ready", 32'(alloc_ready), 1);
        idle();

        // Checkpoint in the allocation cycle, then restore with a concurrent free
        do_reset();
        alloc_req = 2'b11;
        ckpt_save = 1'b1;
        ckpt_idx  = 2'd1;
        tick();
        ckpt_save = 1'b0;
        tick();
        tick();
        chk("pre_restore_count", 32'(free_count), 26);
        alloc_req    = 2'b11;
        restore_en   = 1'b1;
        restore_idx  = 2'd1;
        free_en      = 2'b01;
        free_phys[0] = 6'd9;
        #1;
        chk("restore_blocks_alloc", 32'(alloc_ready), 0);
        tick();
        idle();
        alloc_req = 2'b11;
        #1;
        chk("restored_tag0", 32'(alloc_phys[0]), 34);
        chk("restored_tag1", 32'(alloc_phys[1]), 35);
        chk("restored_count", 32'(free_count), 31);
        idle();

        // Full list: balanced alloc+free is legal, a lone free overflows
        do_reset();
        alloc_req    = 2'b01;
        free_en      = 2'b01;
        free_phys[0] = 6'd3;
        tick();
        idle();
        chk("balanced_count", 32'(free_count), 32);
        chk("balanced_ovf", 32'(overflow_err), 0);
        free_en      = 2'b01;
        free_phys[0] = 6'd4;
        tick();
        idle();
        chk("ovf_set", 32'(overflow_err), 1);
        chk("ovf_count", 32'(free_count), 32);
        tick();
        chk("ovf_sticky", 32'(overflow_err), 1);
        do_reset();
        chk("ovf_cleared", 32'(overflow_err), 0);
        chk("ovf_rst_count", 32'(free_count), 32);

        // Random allocs/frees against a FIFO scoreboard
        fl.delete();
        pool.delete();
        for (int t = 32; t < 64; t++) fl.push_back(t);
        for (int cyc = 0; cyc < 200; cyc++) begin
            idle();
            rq = 2'($urandom_range(0, 3));
            fe = 2'($urandom_range(0, 3));
            if ($countones(fe) > pool.size()) fe = '0;
            for (int j = 0; j < FREE_W; j++) begin
                if (fe[j]) begin
                    idx = $urandom_range(0, pool.size() - 1);
                    free_phys[j] = PW'(pool[idx]);
                    pool.delete(idx);
                end
            end
            alloc_req = rq;
            free_en   = fe;
            #1;
            nreq      = $countones(rq);
            exp_ready = (fl.size() >= nreq);
            chk("rnd_ready", 32'(alloc_ready), 32'(exp_ready));
            r = 0;
            for (int i = 0; i < ALLOC_W; i++) begin
                if (rq[i]) begin
                    if (exp_ready) chk("rnd_tag", 32'(alloc_phys[i]), 32'(fl[r]));
                    r++;
                end
            end
            tick();
            if (exp_ready) begin
                for (int k = 0; k < nreq; k++) pool.push_back(fl.pop_front());
            end
            for (int j = 0; j < FREE_W; j++) begin
                if (fe[j]) fl.push_back(int'(free_phys[j]));
            end
            chk("rnd_count", 32'(free_count), 32'(fl.size()));
        end
        idle();
        #1;
        chk("rnd_no_ovf", 32'(overflow_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
